// File: rtl/fir_out_requant_dec.sv
// Output requantiser for the FIR result stream: round-half-up by SHIFT, saturate to Win bits,
// optional decimation by DEC, with a sticky saturation flag and an emitted-sample counter.
module fir_out_requant_dec #(
  parameter int Win   = 16,
  parameter int Wd    = 19,
  parameter int SHIFT = 3,
  parameter int DEC   = 4,
  parameter int CW    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [Wd-1:0]  din,
  input  logic                  val_in,
  input  logic                  dec_en,
  input  logic                  sat_clr,
  output logic                  val_out,
  output logic signed [Win-1:0] dout,
  output logic                  sat_flag,
  output logic [CW-1:0]         out_cnt
);

  localparam int PW = $clog2(DEC);
  localparam logic [PW-1:0] PH_LAST_C = PW'(DEC - 1);
  localparam logic signed [Wd:0] RND_C = {{(Wd + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
  localparam logic signed [Win:0] MAX_C = {2'b00, {(Win - 1){1'b1}}};
  localparam logic signed [Win:0] MIN_C = {2'b11, {(Win - 1){1'b0}}};

  // Returns {clamped, value}: value is r limited to the signed Win-bit range.
  function automatic logic [Win:0] sat_fn(input logic signed [Win:0] r);
    logic [Win:0] res;
    if (r > MAX_C) begin
      res = {1'b1, MAX_C[Win-1:0]};
    end else if (r < MIN_C) begin
      res = {1'b1, MIN_C[Win-1:0]};
    end else begin
      res = {1'b0, r[Win-1:0]};
    end
    return res;
  endfunction

  logic signed [Wd:0]    sum_s;
  logic signed [Win:0]   r_s;
  logic                  keep_s;
  logic [Win:0]          sat_res_s;

  logic [PW-1:0]         phase_r;
  logic signed [Win:0]   r1_r;
  logic                  v1_r;
  logic                  keep1_r;
  logic                  val_out_r;
  logic signed [Win-1:0] dout_r;
  logic                  sat_flag_r;
  logic [CW-1:0]         out_cnt_r;

  // Rounding add/shift for stage 1, keep decision, and saturation for stage 2.
  always_comb begin
    sum_s     = $signed({din[Wd-1], din}) + RND_C;
    r_s       = (Win + 1)'(sum_s >>> SHIFT);
    keep_s    = !dec_en || (phase_r == {PW{1'b0}});
    sat_res_s = sat_fn(r1_r);
  end

  // Phase counter, stage-1 pipeline and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r    <= {PW{1'b0}};
      r1_r       <= {(Win + 1){1'b0}};
      v1_r       <= 1'b0;
      keep1_r    <= 1'b0;
      val_out_r  <= 1'b0;
      dout_r     <= {Win{1'b0}};
      sat_flag_r <= 1'b0;
      out_cnt_r  <= {CW{1'b0}};
    end else begin
      // Phase is pinned to 0 while decimation is off so the first sample after enabling is kept.
      if (!dec_en) begin
        phase_r <= {PW{1'b0}};
      end else if (val_in) begin
        phase_r <= (phase_r == PH_LAST_C) ? {PW{1'b0}} : phase_r + PW'(1'b1);
      end else begin
        phase_r <= phase_r;
      end

      r1_r    <= r_s;
      v1_r    <= val_in;
      keep1_r <= keep_s;

      if (v1_r && keep1_r) begin
        dout_r    <= sat_res_s[Win-1:0];
        val_out_r <= 1'b1;
        out_cnt_r <= out_cnt_r + CW'(1'b1);
      end else begin
        dout_r    <= dout_r;
        val_out_r <= 1'b0;
        out_cnt_r <= out_cnt_r;
      end

      // Saturation is flagged for discarded samples too; a set beats a simultaneous clear.
      if (v1_r && sat_res_s[Win]) begin
        sat_flag_r <= 1'b1;
      end else if (sat_clr) begin
        sat_flag_r <= 1'b0;
      end else begin
        sat_flag_r <= sat_flag_r;
      end
    end
  end

  assign val_out  = val_out_r;
  assign dout     = dout_r;
  assign sat_flag = sat_flag_r;
  assign out_cnt  = out_cnt_r;

endmodule

// File: tb/tb_fir_out_requant_dec.sv
// Directed bench for fir_out_requant_dec: expected samples are queued at issue time and
// a negedge monitor pops and compares them (value and arrival cycle) whenever val_out is high.
module tb_fir_out_requant_dec;

  localparam int Win = 16;
  localparam int Wd  = 19;
  localparam int CW  = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic signed [Wd-1:0]  din;
  logic                  val_in;
  logic                  dec_en;
  logic                  sat_clr;
  logic                  val_out;
  logic signed [Win-1:0] dout;
  logic                  sat_flag;
  logic [CW-1:0]         out_cnt;

  typedef struct {
    logic signed [Win-1:0] d;
    int                    c;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  fir_out_requant_dec #(.Win(Win), .Wd(Wd), .SHIFT(3), .DEC(4), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .val_in   (val_in),
    .dec_en   (dec_en),
    .sat_clr  (sat_clr),
    .val_out  (val_out),
    .dout     (dout),
    .sat_flag (sat_flag),
    .out_cnt  (out_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every val_out pulse must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    if (!rst && val_out) begin
      n_cmp = n_cmp + 1;
      if (q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_val_out: got dout=%0d at cycle %0d, required no output", dout, cyc);
      end else begin
        mon_e = q.pop_front();
        if (dout !== mon_e.d || cyc != mon_e.c) begin
          n_err = n_err + 1;
          $display("FAIL out_sample: got dout=%0d at cycle %0d, required %0d at cycle %0d",
                   dout, cyc, mon_e.d, mon_e.c);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic send(input int d, input logic de, input logic keep, input int e);
    @(negedge clk);
    din    = d[Wd-1:0];
    dec_en = de;
    val_in = 1'b1;
    if (keep) q.push_back('{Win'(e), cyc + 2});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      val_in = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; din = '0; val_in = 1'b0; dec_en = 1'b0; sat_clr = 1'b0;
    #12;
    chk("reset_val_out", int'(val_out), 0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_sat_flag", int'(sat_flag), 0);
    chk("reset_out_cnt", int'(out_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Rounding, pass-through mode
    send(8, 1'b0, 1'b1, 1);    idle(2);
    send(4, 1'b0, 1'b1, 1);    idle(2);
    send(3, 1'b0, 1'b1, 0);    idle(2);
    send(-4, 1'b0, 1'b1, 0);   idle(2);
    send(-5, 1'b0, 1'b1, -1);  idle(2);
    send(-12, 1'b0, 1'b1, -1); idle(3);
    chk("round_out_cnt", int'(out_cnt), 6);
    chk("round_sat_flag", int'(sat_flag), 0);

    // Saturation and sticky flag behaviour
    send(262143, 1'b0, 1'b1, 32767); idle(3);
    chk("sat_pos_flag", int'(sat_flag), 1);
    send(-262144, 1'b0, 1'b1, -32768); idle(3);
    chk("sat_neg_flag_held", int'(sat_flag), 1);
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
    chk("sat_clr_flag", int'(sat_flag), 0);
    send(262143, 1'b0, 1'b1, 32767);
    @(negedge clk); val_in = 1'b0; sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
    chk("sat_set_beats_clr", int'(sat_flag), 1);
    idle(2);
    chk("sat_out_cnt", int'(out_cnt), 9);
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
    chk("sat_clr_again", int'(sat_flag), 0);

    // Decimation by 4, back-to-back input
    for (int k = 1; k <= 8; k++) send(8 * k, 1'b1, (k == 1) || (k == 5), (k == 1) ? 1 : 5);
    idle(3);
    chk("dec_out_cnt", int'(out_cnt), 11);

    // Saturation on a discarded phase still sets the flag
    send(8, 1'b1, 1'b1, 1);
    send(262143, 1'b1, 1'b0, 0);
    idle(3);
    chk("dec_sat_flag", int'(sat_flag), 1);
    chk("dec_sat_out_cnt", int'(out_cnt), 12);
    @(negedge clk); dec_en = 1'b0;
    idle(1);

    // Mode switch: decimate, pass-through, re-enable
    send(16, 1'b1, 1'b1, 2);
    send(24, 1'b1, 1'b0, 0);
    send(32, 1'b0, 1'b1, 4);
    send(40, 1'b0, 1'b1, 5);
    send(48, 1'b0, 1'b1, 6);
    send(56, 1'b1, 1'b1, 7);
    send(64, 1'b1, 1'b0, 0);
    idle(3);
    chk("mode_out_cnt", int'(out_cnt), 17);
    @(negedge clk); dec_en = 1'b0;
    idle(1);

    // Async reset with a kept sample in flight and phase advanced
    send(8, 1'b1, 1'b1, 1);
    send(16, 1'b1, 1'b0, 0);
    send(24, 1'b1, 1'b0, 0);
    send(32, 1'b1, 1'b0, 0);
    idle(3);
    chk("pre_rst_out_cnt", int'(out_cnt), 18);
    send(262143, 1'b1, 1'b0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1; val_in = 1'b0;
    #1;
    chk("async_rst_val_out", int'(val_out), 0);
    chk("async_rst_dout", int'(dout), 0);
    chk("async_rst_sat_flag", int'(sat_flag), 0);
    chk("async_rst_out_cnt", int'(out_cnt), 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    send(16, 1'b1, 1'b1, 2);
    idle(4);
    chk("post_rst_out_cnt", int'(out_cnt), 1);
    chk("post_rst_sat_flag", int'(sat_flag), 0);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
